rhythm_lane_engine: RTL and testbench

RHYTHM_LANE_ENGINE -- requirements
Module: rhythm_lane_engine

---
 rtl/rhythm_pkg.sv | 14 +
 rtl/rhythm_lane_engine_lane_judge.sv | 30 +++
 rtl/rhythm_lane_engine.sv | 145 ++++++++++++++
 tb/tb_rhythm_lane_engine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rhythm_pkg.sv
// Shared state encoding and scoring constants for the rhythm lane engine.
package rhythm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int PTS_PERFECT       = 3;
  localparam int PTS_GOOD          = 1;
  localparam int COMBO_MULT_THRESH = 16;

endpackage

// File: rtl/rhythm_lane_engine_lane_judge.sv
// One lane column: key rising-edge detect and the perfect/good/miss decision
// against the pre-shift bottom two rows. Decisions are combinational; the top registers them.
module lane_judge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic scroll_tick_i,
  input  logic key_i,
  input  logic bottom_i,
  input  logic row_good_i,
  output logic perfect_o,
  output logic good_o,
  output logic miss_o
);

  logic key_q;
  logic key_edge;

  always_ff @(posedge clk_i) begin
    if (rst_i) key_q <= 1'b0;
    else       key_q <= key_i;
  end

  assign key_edge  = key_i & ~key_q;
  assign perfect_o = active_i & key_edge & bottom_i;
  assign good_o    = active_i & key_edge & ~bottom_i & row_good_i;
  // A bottom note hit this cycle is cleared before the shift, so it never misses.
  assign miss_o    = active_i & scroll_tick_i & bottom_i & ~key_edge;

endmodule

// File: rtl/rhythm_lane_engine.sv
// Falling-note matrix, per-lane judging, score/combo tracking and game FSM.
// Define RHYTHM_COMBO_MULT_EN to double perfect points once combo reaches the threshold.
module rhythm_lane_engine
  import rhythm_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int DEPTH     = 16,
  parameter int SCORE_W   = 32,
  parameter int COMBO_W   = 8
) (
  input  logic                          clk_50m,
  input  logic                          rst,
  input  logic                          game_active,
  input  logic                          scroll_tick,
  input  logic                          note_valid,
  input  logic [NUM_LANES-1:0]          new_note,
  input  logic [NUM_LANES-1:0]          key_press,
  output logic [DEPTH*NUM_LANES-1:0]    lane_rows,
  output logic [SCORE_W-1:0]            score,
  output logic [COMBO_W-1:0]            combo,
  output logic [COMBO_W-1:0]            max_combo,
  output logic [NUM_LANES-1:0]          hit_perfect,
  output logic [NUM_LANES-1:0]          hit_good,
  output logic [NUM_LANES-1:0]          miss,
  output logic [1:0]                    state,
  output logic                          game_done
);

  state_e                       state_q;
  logic                         game_active_q;
  logic                         game_done_q;
  logic [DEPTH*NUM_LANES-1:0]   matrix_q, matrix_d, judged;
  logic [SCORE_W-1:0]           score_q, score_d;
  logic [COMBO_W-1:0]           combo_q, combo_d, max_combo_q;
  logic [NUM_LANES-1:0]         perfect_q, good_q, miss_q;
  logic [NUM_LANES-1:0]         perf_c, good_c, miss_c;
  logic [NUM_LANES-1:0]         bottom, row_good, row0_in;
  logic [SCORE_W:0]             score_sum;
  logic [COMBO_W:0]             combo_sum;
  logic                         active;
  int                           pts, hits, perf_pts;

  assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bottom   = matrix_q[(DEPTH-1)*NUM_LANES +: NUM_LANES];
  assign row_good = matrix_q[(DEPTH-2)*NUM_LANES +: NUM_LANES];
  assign row0_in  = (state_q == ST_RUN && note_valid) ? new_note : '0;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lane_judge u_judge (
      .clk_i         (clk_50m),
      .rst_i         (rst),
      .active_i      (active),
      .scroll_tick_i (scroll_tick),
      .key_i         (key_press[l]),
      .bottom_i      (bottom[l]),
      .row_good_i    (row_good[l]),
      .perfect_o     (perf_c[l]),
      .good_o        (good_c[l]),
      .miss_o        (miss_c[l])
    );
  end

  // Judged notes are removed first, then the shift sees the cleaned matrix.
  always_comb begin
    judged = matrix_q;
    judged[(DEPTH-1)*NUM_LANES +: NUM_LANES] = bottom & ~perf_c;
    judged[(DEPTH-2)*NUM_LANES +: NUM_LANES] = row_good & ~good_c;
    matrix_d = matrix_q;
    if (active) begin
      matrix_d = judged;
      if (scroll_tick) matrix_d = {judged[(DEPTH-1)*NUM_LANES-1:0], row0_in};
    end
  end

  always_comb begin
    pts  = 0;
    hits = 0;
`ifdef RHYTHM_COMBO_MULT_EN
    perf_pts = (int'(combo_q) >= COMBO_MULT_THRESH) ? 2 * PTS_PERFECT : PTS_PERFECT;
`else
    perf_pts = PTS_PERFECT;
`endif
    for (int l = 0; l < NUM_LANES; l++) begin
      if (perf_c[l]) begin pts += perf_pts; hits++; end
      if (good_c[l]) begin pts += PTS_GOOD; hits++; end
    end
    score_sum = {1'b0, score_q} + (SCORE_W+1)'(pts);
    score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    combo_sum = {1'b0, combo_q} + (COMBO_W+1)'(hits);
    combo_d   = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
    if (|miss_c) combo_d = '0;
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      game_active_q <= 1'b0;
      game_done_q   <= 1'b0;
      matrix_q      <= '0;
      score_q       <= '0;
      combo_q       <= '0;
      max_combo_q   <= '0;
      perfect_q     <= '0;
      good_q        <= '0;
      miss_q        <= '0;
    end else begin
      game_active_q <= game_active;
      game_done_q   <= 1'b0;
      matrix_q      <= matrix_d;
      perfect_q     <= perf_c;
      good_q        <= good_c;
      miss_q        <= miss_c;
      if (active) begin
        score_q <= score_d;
        combo_q <= combo_d;
        if (combo_d > max_combo_q) max_combo_q <= combo_d;
      end
      case (state_q)
        ST_IDLE: if (game_active && !game_active_q) begin
          state_q     <= ST_RUN;
          score_q     <= '0;
          combo_q     <= '0;
          max_combo_q <= '0;
        end
        ST_RUN: if (!game_active) state_q <= ST_DRAIN;
        ST_DRAIN: if (matrix_q == '0) begin
          state_q     <= ST_IDLE;
          game_done_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign lane_rows   = matrix_q;
  assign score       = score_q;
  assign combo       = combo_q;
  assign max_combo   = max_combo_q;
  assign hit_perfect = perfect_q;
  assign hit_good    = good_q;
  assign miss        = miss_q;
  assign state       = state_q;
  assign game_done   = game_done_q;

endmodule

// File: tb/tb_rhythm_lane_engine.sv
// Directed bench for rhythm_lane_engine with default parameters (4 lanes, 16 rows).
module tb_rhythm_lane_engine;

  logic        clk_50m = 1'b0;
  logic        rst = 1'b1;
  logic        game_active = 1'b0;
  logic        scroll_tick = 1'b0;
  logic        note_valid = 1'b0;
  logic [3:0]  new_note = '0;
  logic [3:0]  key_press = '0;
  logic [63:0] lane_rows;
  logic [31:0] score;
  logic [7:0]  combo, max_combo;
  logic [3:0]  hit_perfect, hit_good, miss;
  logic [1:0]  state;
  logic        game_done;

  int vectors = 0;
  int miscompares = 0;

  rhythm_lane_engine dut (
    .clk_50m(clk_50m), .rst(rst), .game_active(game_active), .scroll_tick(scroll_tick),
    .note_valid(note_valid), .new_note(new_note), .key_press(key_press),
    .lane_rows(lane_rows), .score(score), .combo(combo), .max_combo(max_combo),
    .hit_perfect(hit_perfect), .hit_good(hit_good), .miss(miss),
    .state(state), .game_done(game_done)
  );

  always #10 clk_50m = ~clk_50m;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic push(input logic [3:0] lanes);
    scroll_tick = 1'b1; note_valid = 1'b1; new_note = lanes;
    tick();
    scroll_tick = 1'b0; note_valid = 1'b0; new_note = '0;
  endtask

  task automatic scroll_n(input int n);
    scroll_tick = 1'b1;
    for (int i = 0; i < n; i++) tick();
    scroll_tick = 1'b0;
  endtask

  task automatic round_press(input logic [3:0] lanes);
    push(lanes);
    scroll_n(15);
    key_press = lanes;
    tick();
  endtask

  task automatic release_keys();
    key_press = '0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d exp 0", state); end
    vectors++; if (score !== 32'd0) begin miscompares++; $display("FAIL reset_score: got %0d exp 0", score); end
    vectors++; if (combo !== 8'd0 || max_combo !== 8'd0) begin miscompares++; $display("FAIL reset_combo: got %0d/%0d exp 0/0", combo, max_combo); end
    vectors++; if (lane_rows !== 64'd0) begin miscompares++; $display("FAIL reset_rows: got %h exp 0", lane_rows); end
    vectors++; if ({hit_perfect, hit_good, miss, game_done} !== 13'd0) begin miscompares++; $display("FAIL reset_pulses: got %h exp 0", {hit_perfect, hit_good, miss, game_done}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_start();
    game_active = 1'b1;
    tick();
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL start_state: got %0d exp 1", state); end
  endtask

  task automatic test_perfect();
    push(4'b0001);
    scroll_n(15);
    vectors++; if (lane_rows !== (64'd1 << 60)) begin miscompares++; $display("FAIL perfect_bottom_row: got %h exp %h", lane_rows, 64'd1 << 60); end
    key_press = 4'b0001;
    tick();
    vectors++; if (hit_perfect !== 4'b0001) begin miscompares++; $display("FAIL perfect_pulse: got %b exp 0001", hit_perfect); end
    vectors++; if (score !== 32'd3) begin miscompares++; $display("FAIL perfect_score: got %0d exp 3", score); end
    vectors++; if (combo !== 8'd1) begin miscompares++; $display("FAIL perfect_combo: got %0d exp 1", combo); end
    vectors++; if (lane_rows !== 64'd0) begin miscompares++; $display("FAIL perfect_cleared: got %h exp 0", lane_rows); end
    release_keys();
    vectors++; if (hit_perfect !== 4'b0000) begin miscompares++; $display("FAIL perfect_one_cycle: got %b exp 0000", hit_perfect); end
  endtask

  task automatic test_good();
    push(4'b0010);
    scroll_n(14);
    vectors++; if (lane_rows !== (64'd1 << 57)) begin miscompares++; $display("FAIL good_row14: got %h exp %h", lane_rows, 64'd1 << 57); end
    key_press = 4'b0010;
    tick();
    vectors++; if (hit_good !== 4'b0010 || hit_perfect !== 4'b0000) begin miscompares++; $display("FAIL good_pulse: got good=%b perf=%b exp 0010/0000", hit_good, hit_perfect); end
    vectors++; if (score !== 32'd4 || combo !== 8'd2) begin miscompares++; $display("FAIL good_score: got %0d/%0d exp 4/2", score, combo); end
    vectors++; if (lane_rows !== 64'd0) begin miscompares++; $display("FAIL good_cleared: got %h exp 0", lane_rows); end
    release_keys();
    key_press = 4'b0100;
    tick();
    vectors++; if ({hit_perfect, hit_good, miss} !== 12'd0) begin miscompares++; $display("FAIL empty_lane_pulse: got %h exp 0", {hit_perfect, hit_good, miss}); end
    vectors++; if (score !== 32'd4 || combo !== 8'd2) begin miscompares++; $display("FAIL empty_lane_score: got %0d/%0d exp 4/2", score, combo); end
    release_keys();
  endtask

  task automatic test_same_cycle();
    push(4'b0001);
    scroll_n(15);
    key_press = 4'b0001;
    scroll_tick = 1'b1;
    tick();
    scroll_tick = 1'b0;
    vectors++; if (hit_perfect !== 4'b0001 || miss !== 4'b0000) begin miscompares++; $display("FAIL same_cycle_pulse: got perf=%b miss=%b exp 0001/0000", hit_perfect, miss); end
    vectors++; if (score !== 32'd7 || combo !== 8'd3) begin miscompares++; $display("FAIL same_cycle_score: got %0d/%0d exp 7/3", score, combo); end
    vectors++; if (lane_rows !== 64'd0) begin miscompares++; $display("FAIL same_cycle_rows: got %h exp 0", lane_rows); end
    release_keys();
    round_press(4'b0011);
    vectors++; if (score !== 32'd13 || combo !== 8'd5 || max_combo !== 8'd5) begin miscompares++; $display("FAIL two_lane: got %0d/%0d/%0d exp 13/5/5", score, combo, max_combo); end
    release_keys();
  endtask

  task automatic test_miss();
    push(4'b0100);
    scroll_n(16);
    vectors++; if (miss !== 4'b0100) begin miscompares++; $display("FAIL miss_pulse: got %b exp 0100", miss); end
    vectors++; if (combo !== 8'd0 || max_combo !== 8'd5) begin miscompares++; $display("FAIL miss_combo: got %0d/%0d exp 0/5", combo, max_combo); end
    vectors++; if (score !== 32'd13) begin miscompares++; $display("FAIL miss_score: got %0d exp 13", score); end
    tick();
    vectors++; if (miss !== 4'b0000) begin miscompares++; $display("FAIL miss_one_cycle: got %b exp 0000", miss); end
  endtask

  task automatic test_all_lanes();
    round_press(4'b1111);
    vectors++; if (hit_perfect !== 4'b1111) begin miscompares++; $display("FAIL all_lanes_pulse: got %b exp 1111", hit_perfect); end
    vectors++; if (score !== 32'd25 || combo !== 8'd4 || max_combo !== 8'd5) begin miscompares++; $display("FAIL all_lanes_score: got %0d/%0d/%0d exp 25/4/5", score, combo, max_combo); end
    release_keys();
  endtask

  task automatic test_drain();
    int done_cnt;
    int done_at;
    int idle_at;
    bit inserted;
    done_cnt = 0; done_at = 0; idle_at = 0; inserted = 1'b0;
    push(4'b0001);
    push(4'b0010);
    push(4'b0100);
    scroll_n(3);
    vectors++; if (lane_rows !== ((64'd1 << 20) | (64'd2 << 16) | (64'd4 << 12))) begin miscompares++; $display("FAIL drain_setup_rows: got %h", lane_rows); end
    game_active = 1'b0;
    tick();
    vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL drain_state: got %0d exp 2", state); end
    scroll_tick = 1'b1; note_valid = 1'b1; new_note = 4'b1111;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (game_done) begin done_cnt++; done_at = i; end
      if (state == 2'd0 && idle_at == 0) idle_at = i;
      if (lane_rows[3:0] != 4'd0) inserted = 1'b1;
    end
    scroll_tick = 1'b0; note_valid = 1'b0; new_note = '0;
    vectors++; if (inserted !== 1'b0) begin miscompares++; $display("FAIL drain_no_insert: got %b exp 0", inserted); end
    vectors++; if (idle_at !== 14) begin miscompares++; $display("FAIL drain_idle_cycle: got %0d exp 14", idle_at); end
    vectors++; if (done_cnt !== 1 || done_at !== 14) begin miscompares++; $display("FAIL drain_game_done: got count %0d at %0d exp 1 at 14", done_cnt, done_at); end
  endtask

  task automatic test_reset_mid_run();
    game_active = 1'b1;
    tick();
    vectors++; if (state !== 2'd1 || score !== 32'd0 || combo !== 8'd0 || max_combo !== 8'd0) begin miscompares++; $display("FAIL restart_clear: got st=%0d %0d/%0d/%0d exp 1 0/0/0", state, score, combo, max_combo); end
    round_press(4'b0011);
    vectors++; if (score !== 32'd6 || combo !== 8'd2) begin miscompares++; $display("FAIL pre_reset_score: got %0d/%0d exp 6/2", score, combo); end
    rst = 1'b1;
    key_press = 4'b1111;
    tick();
    vectors++; if (state !== 2'd0 || score !== 32'd0 || combo !== 8'd0 || max_combo !== 8'd0) begin miscompares++; $display("FAIL mid_reset_regs: got st=%0d %0d/%0d/%0d exp 0 0/0/0", state, score, combo, max_combo); end
    vectors++; if (lane_rows !== 64'd0 || {hit_perfect, hit_good, miss, game_done} !== 13'd0) begin miscompares++; $display("FAIL mid_reset_outputs: got rows=%h pulses=%h exp 0", lane_rows, {hit_perfect, hit_good, miss, game_done}); end
    rst = 1'b0; game_active = 1'b0; key_press = '0;
    tick();
    game_active = 1'b1;
    tick();
  endtask

`ifdef RHYTHM_COMBO_MULT_EN
  task automatic test_combo_mult();
    for (int r = 0; r < 3; r++) begin round_press(4'b1111); release_keys(); end
    round_press(4'b0111);
    release_keys();
    vectors++; if (score !== 32'd45 || combo !== 8'd15) begin miscompares++; $display("FAIL mult_setup: got %0d/%0d exp 45/15", score, combo); end
    round_press(4'b0001);
    vectors++; if (score !== 32'd48 || combo !== 8'd16) begin miscompares++; $display("FAIL mult_at_15: got %0d/%0d exp 48/16", score, combo); end
    release_keys();
    round_press(4'b0001);
    vectors++; if (score !== 32'd54 || combo !== 8'd17) begin miscompares++; $display("FAIL mult_at_16: got %0d/%0d exp 54/17", score, combo); end
    release_keys();
  endtask
`endif

  task automatic test_combo_saturate();
    for (int r = 0; r < 64; r++) begin round_press(4'b1111); release_keys(); end
    vectors++; if (combo !== 8'd255 || max_combo !== 8'd255) begin miscompares++; $display("FAIL combo_saturate: got %0d/%0d exp 255/255", combo, max_combo); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_perfect();
    test_good();
    test_same_cycle();
    test_miss();
    test_all_lanes();
    test_drain();
    test_reset_mid_run();
`ifdef RHYTHM_COMBO_MULT_EN
    test_combo_mult();
`endif
    test_combo_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
